// File: rtl/conv_layer_sched.sv
// rtl/conv_layer_sched.sv - convolution layer sequencer: channel/pixel/tap walk, address generation, adder hold and write counting
module conv_layer_sched #(
    parameter int NUM_TAP   = 25,
    parameter int NUM_PIX   = 324,
    parameter int NUM_CH    = 36,
    parameter int DRAIN_MAX = 64
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic        next_ready,
    input  logic        wr_in,
    output logic        tap_valid,
    output logic [13:0] feat_addr,
    output logic [9:0]  wgt_addr,
    output logic [5:0]  b_ind,
    output logic        adder_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TAP_W = $clog2(NUM_TAP + 1);
    localparam int PIX_W = $clog2(NUM_PIX + 1);
    localparam int WR_W  = $clog2(NUM_PIX + 1);
    localparam int DR_W  = $clog2(DRAIN_MAX + 1);

    localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(NUM_TAP - 1);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NUM_PIX - 1);
    localparam logic [5:0]       LAST_CH   = 6'(NUM_CH - 1);
    localparam logic [WR_W-1:0]  FULL_WR   = WR_W'(NUM_PIX);
    localparam logic [DR_W-1:0]  LAST_DR   = DR_W'(DRAIN_MAX - 1);
    localparam logic [9:0]       TAP_STEP  = 10'(NUM_TAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state;
    logic [TAP_W-1:0] tap;
    logic [PIX_W-1:0] pix;
    logic [WR_W-1:0]  wr_cnt;
    logic [DR_W-1:0]  drain_cnt;
    logic [9:0]       wgt_base;

    always_ff @(posedge clk_in or posedge rst_n) begin
        if (rst_n) begin
            state      <= S_IDLE;
            tap        <= '0;
            pix        <= '0;
            wr_cnt     <= '0;
            drain_cnt  <= '0;
            wgt_base   <= '0;
            tap_valid  <= 1'b0;
            feat_addr  <= '0;
            wgt_addr   <= '0;
            b_ind      <= '0;
            adder_hold <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        b_ind    <= '0;
                        wgt_base <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    tap       <= '0;
                    pix       <= '0;
                    wr_cnt    <= '0;
                    drain_cnt <= '0;
                    feat_addr <= '0;
                    wgt_addr  <= wgt_base;
                    if (next_ready) begin
                        tap_valid  <= 1'b1;
                        adder_hold <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    // feat_addr is contiguous across pixels; wgt_addr rewinds every pixel
                    feat_addr <= feat_addr + 14'd1;
                    if (tap == LAST_TAP) begin
                        tap      <= '0;
                        pix      <= pix + 1'b1;
                        wgt_addr <= wgt_base;
                        if (pix == LAST_PIX) begin
                            tap_valid <= 1'b0;
                            state     <= S_DRAIN;
                        end
                    end else begin
                        tap      <= tap + 1'b1;
                        wgt_addr <= wgt_addr + 10'd1;
                    end
                end
                S_DRAIN: begin
                    if (wr_cnt == FULL_WR) begin
                        adder_hold <= 1'b1;
                        state      <= S_NEXT;
                    end else if (drain_cnt == LAST_DR) begin
                        err        <= 1'b1;
                        adder_hold <= 1'b1;
                        state      <= S_NEXT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (b_ind == LAST_CH) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        b_ind    <= b_ind + 6'd1;
                        wgt_base <= wgt_base + TAP_STEP;
                        state    <= S_ARM;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // a write outside RUN/DRAIN or beyond a full channel is a protocol error
            if (wr_in) begin
                if ((state == S_RUN || state == S_DRAIN) && wr_cnt != FULL_WR) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb/tb_conv_layer_sched.sv - scoreboard bench for conv_layer_sched with small layer parameters
module tb_conv_layer_sched;

    localparam int NT     = 3;
    localparam int NP     = 4;
    localparam int NC     = 2;
    localparam int DM     = 8;
    localparam int WR_LAT = 6;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        next_ready = 1'b0;
    logic        wr_in;
    logic        model_wr = 1'b0;
    logic        inj_wr = 1'b0;
    logic        tap_valid;
    logic [13:0] feat_addr;
    logic [9:0]  wgt_addr;
    logic [5:0]  b_ind;
    logic        adder_hold;
    logic        busy;
    logic        done;
    logic        err;

    assign wr_in = model_wr | inj_wr;

    conv_layer_sched #(
        .NUM_TAP  (NT),
        .NUM_PIX  (NP),
        .NUM_CH   (NC),
        .DRAIN_MAX(DM)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .next_ready(next_ready),
        .wr_in     (wr_in),
        .tap_valid (tap_valid),
        .feat_addr (feat_addr),
        .wgt_addr  (wgt_addr),
        .b_ind     (b_ind),
        .adder_hold(adder_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [13:0] f;
        logic [9:0]  w;
        logic [5:0]  b;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   model_tap = 0;
    int   model_pix = 0;
    int   drop_idx = -1;
    logic [WR_LAT:0] pipe = '0;

    // adder model: one write pulse WR_LAT cycles after each pixel's last tap
    always @(negedge clk_in) begin : wr_model
        logic flag;
        flag = 1'b0;
        if (rst_n) begin
            pipe      = '0;
            model_wr  = 1'b0;
            model_tap = 0;
        end else begin
            if (tap_valid === 1'b1) begin
                if (model_tap == NT - 1) begin
                    model_tap = 0;
                    flag = (model_pix != drop_idx);
                    model_pix++;
                end else begin
                    model_tap++;
                end
            end
            pipe = {pipe[WR_LAT-1:0], flag};
            model_wr = pipe[WR_LAT];
        end
    end

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (!rst_n && tap_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL tap_extra got f=%0d w=%0d b=%0d exp none", feat_addr, wgt_addr, b_ind);
            end else begin
                e = sb.pop_front();
                if ({feat_addr, wgt_addr, b_ind} !== {e.f, e.w, e.b}) begin
                    bad++;
                    $display("FAIL tap_seq got f=%0d w=%0d b=%0d exp f=%0d w=%0d b=%0d",
                             feat_addr, wgt_addr, b_ind, e.f, e.w, e.b);
                end
            end
        end
    end

    task automatic run_layer(input string name, input int hold, input bit poke,
                             input int drop, input bit inj, input bit exp_err);
        int   cyc;
        int   exp_done;
        int   dones;
        int   arm_seen;
        int   err_cyc;
        int   tv[NC];
        exp_t e;
        for (int c = 0; c < NC; c++)
            for (int p = 0; p < NP; p++)
                for (int t = 0; t < NT; t++) begin
                    e.f = 14'(p * NT + t);
                    e.w = 10'(c * NT + t);
                    e.b = 6'(c);
                    sb.push_back(e);
                end
        exp_done = NC * (NT * NP + WR_LAT + 3) + 1 + (hold > 0 ? hold - 1 : 0)
                 + (drop >= 0 ? DM - WR_LAT - 1 : 0);
        dones = 0;
        arm_seen = 0;
        err_cyc = -1;
        for (int i = 0; i < NC; i++) tv[i] = 0;
        @(negedge clk_in);
        model_tap = 0;
        model_pix = 0;
        drop_idx = drop;
        start = 1'b1;
        next_ready = 1'b1;
        cyc = 0;
        while (cyc < exp_done + 5) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                total++;
                if ({busy, tap_valid, adder_hold, err, b_ind} !== {1'b1, 1'b0, 1'b1, 1'b0, 6'd0}) begin
                    bad++;
                    $display("FAIL %s arm_state got busy=%b tv=%b hold=%b err=%b b=%0d exp 1 0 1 0 0",
                             name, busy, tap_valid, adder_hold, err, b_ind);
                end
                if (inj) inj_wr = 1'b1;
            end
            if (cyc == 2) begin
                inj_wr = 1'b0;
                total++;
                if ({tap_valid, adder_hold} !== 2'b10) begin
                    bad++;
                    $display("FAIL %s first_tap got tv=%b hold=%b exp tv=1 hold=0", name, tap_valid, adder_hold);
                end
                if (hold > 0) next_ready = 1'b0;
            end
            if (poke && cyc == 6) start = 1'b1;
            if (poke && cyc == 7) start = 1'b0;
            if (hold > 0 && arm_seen < hold && b_ind === 6'd1 && adder_hold === 1'b1 && busy === 1'b1) begin
                arm_seen++;
                total++;
                if (tap_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s hold_tv got %b exp 0", name, tap_valid);
                end
                if (arm_seen == hold) next_ready = 1'b1;
            end
            if (tap_valid === 1'b1 && int'(b_ind) < NC) tv[int'(b_ind)]++;
            if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
            if (done === 1'b1) begin
                dones++;
                total++;
                if (cyc != exp_done) begin
                    bad++;
                    $display("FAIL %s done_cycle got %0d exp %0d", name, cyc, exp_done);
                end
                total++;
                if (err !== exp_err) begin
                    bad++;
                    $display("FAIL %s done_err got %b exp %b", name, err, exp_err);
                end
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s done_count got %0d exp 1", name, dones);
        end
        for (int i = 0; i < NC; i++) begin
            total++;
            if (tv[i] != NT * NP) begin
                bad++;
                $display("FAIL %s tap_count ch%0d got %0d exp %0d", name, i, tv[i], NT * NP);
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s sb_left got %0d exp 0", name, sb.size());
        end
        total++;
        if ({busy, adder_hold, b_ind} !== {1'b0, 1'b1, 6'(NC - 1)}) begin
            bad++;
            $display("FAIL %s idle_after got busy=%b hold=%b b=%0d exp 0 1 %0d", name, busy, adder_hold, b_ind, NC - 1);
        end
        if (drop >= 0) begin
            total++;
            if (err_cyc != 1 + NT * NP + DM + 1) begin
                bad++;
                $display("FAIL %s err_cycle got %0d exp %0d", name, err_cyc, 1 + NT * NP + DM + 1);
            end
        end
        sb.delete();
        drop_idx = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        total++;
        if ({tap_valid, feat_addr, wgt_addr, b_ind, adder_hold, busy, done, err}
            !== {1'b0, 14'd0, 10'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals got tv=%b f=%0d w=%0d b=%0d hold=%b busy=%b done=%b err=%b exp 0 0 0 0 1 0 0 0",
                     tap_valid, feat_addr, wgt_addr, b_ind, adder_hold, busy, done, err);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        total++;
        if ({tap_valid, adder_hold, busy, done} !== 4'b0100) begin
            bad++;
            $display("FAIL idle_hold got tv=%b hold=%b busy=%b done=%b exp 0 1 0 0", tap_valid, adder_hold, busy, done);
        end
    endtask

    task automatic test_basic();
        run_layer("basic", 0, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_ready_hold();
        run_layer("ready_hold", 5, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_drain_timeout();
        run_layer("drain_timeout", 0, 1'b0, NP - 1, 1'b0, 1'b1);
    endtask

    task automatic test_arm_wr();
        run_layer("arm_wr", 0, 1'b0, -1, 1'b1, 1'b1);
        run_layer("err_clear", 0, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        bit   any_done;
        for (int p = 0; p < NP; p++)
            for (int t = 0; t < NT; t++) begin
                e.f = 14'(p * NT + t);
                e.w = 10'(t);
                e.b = 6'd0;
                sb.push_back(e);
            end
        @(negedge clk_in);
        model_tap = 0;
        model_pix = 0;
        start = 1'b1;
        next_ready = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        n = 0;
        while (!(tap_valid === 1'b1 && feat_addr === 14'(2 * NT)) && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL rst_mid_reach got timeout exp feat_addr=%0d", 2 * NT);
        end
        #2 rst_n = 1'b1;
        #1;
        total++;
        if ({tap_valid, feat_addr, wgt_addr, b_ind, adder_hold, busy, done, err}
            !== {1'b0, 14'd0, 10'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_async got tv=%b f=%0d w=%0d b=%0d hold=%b busy=%b done=%b err=%b exp 0 0 0 0 1 0 0 0",
                     tap_valid, feat_addr, wgt_addr, b_ind, adder_hold, busy, done, err);
        end
        @(negedge clk_in);
        #2 rst_n = 1'b0;
        sb.delete();
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            if (done !== 1'b0 || tap_valid !== 1'b0) any_done = 1'b1;
        end
        total++;
        if (any_done) begin
            bad++;
            $display("FAIL rst_mid_quiet got activity exp no done/tap_valid");
        end
        run_layer("after_rst", 0, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_start_during_run();
        run_layer("start_in_run", 0, 1'b1, -1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_hold();
        test_drain_timeout();
        test_arm_wr();
        test_reset_mid();
        test_start_during_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
